// File: rtl/guess_game_pkg.sv
// -----------------------------------------------------------------------------
// guess_game_pkg
// Shared types and constants for the number-guessing round controller.
//   state_t      : round controller states
//   HINT_*       : 2-bit hint codes driven in result[1:0]
//   LFSR_*       : width and feedback taps of the target LFSR
//   lfsr_next()  : one step of the 6-bit Fibonacci LFSR (x^6 + x^5 + 1)
//   hint_of()    : hint code for a guess against the latched target
// -----------------------------------------------------------------------------
package guess_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    CHECK = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_t;

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;
  localparam logic [1:0] HINT_OK   = 2'b11;

  localparam int LFSR_W     = 6;
  localparam int LFSR_TAP_A = 5;
  localparam int LFSR_TAP_B = 4;

  // Shift left and feed back the XOR of bits 5 and 4. This polynomial is
  // primitive, so from any nonzero seed the register walks all 63 nonzero
  // values and never reaches zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B]};
  endfunction

  // "Too low" means the player has to guess higher next time.
  function automatic logic [1:0] hint_of(input logic [5:0] g, input logic [5:0] t);
    if (g == t)     return HINT_OK;
    else if (g < t) return HINT_LOW;
    else            return HINT_HIGH;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous pin into the clk domain through two flops. It then
// emits a registered single-cycle pulse on each rising edge of the
// synchronized level.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   din   : asynchronous input pin
//   pulse : one-cycle high pulse, in the cycle after the third edge following
//           a rise of din
// -----------------------------------------------------------------------------
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-flop synchronizer, a delayed copy for edge detection, and a
  // registered pulse. Because the pulse is registered, the block presents
  // a clean flop output to the controller rather than a combinational edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      pulse  <= sync_q & ~prev_q;
    end
  end

endmodule

// File: rtl/guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// guess_round_ctrl
// Round controller for the 6-bit number-guessing game. A free-running LFSR
// supplies the secret target when a round starts. Guesses are compared on
// synchronized submit edges, and the controller returns a hint, an attempt
// count and a done flag.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   guess      : player guess, 0..63
//   submit     : asynchronous pin; a rising edge evaluates guess
//   new_round  : asynchronous pin; a rising edge starts a new round
//   result     : {done, attempts[2:0], hint[1:0]}, registered
//   target_dbg : latched target, for observation only
// -----------------------------------------------------------------------------
module guess_round_ctrl
  import guess_game_pkg::*;
#(
  parameter int          MAX_TRIES = 7,
  parameter logic [5:0]  SEED      = 6'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] guess,
  input  logic       submit,
  input  logic       new_round,
  output logic [5:0] result,
  output logic [5:0] target_dbg
);

  localparam logic [2:0] MAX_ATTEMPTS = 3'(MAX_TRIES);

  state_t            state_q;
  state_t            state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [5:0]        target_q;
  logic [5:0]        target_d;
  logic [5:0]        guess_q;
  logic [5:0]        guess_d;
  logic [2:0]        attempts_q;
  logic [2:0]        attempts_d;
  logic [2:0]        attempts_inc;
  logic [1:0]        hint_q;
  logic [1:0]        hint_d;
  logic              done_q;
  logic              done_d;
  logic              sub_p;
  logic              nr_p;

  sync_edge u_sync_submit (
    .clk   (clk),
    .rst   (rst),
    .din   (submit),
    .pulse (sub_p)
  );

  sync_edge u_sync_new_round (
    .clk   (clk),
    .rst   (rst),
    .din   (new_round),
    .pulse (nr_p)
  );

  // The LFSR steps every cycle, whatever the FSM is doing. When a round
  // starts, the target is taken from wherever the LFSR happens to be, so it
  // depends on when the player pressed new_round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Attempts saturate at 7 so the 3-bit field can never wrap back to zero.
  always_comb begin
    attempts_inc = (attempts_q == 3'd7) ? 3'd7 : attempts_q + 3'd1;
  end

  // Next-state and datapath logic. A new_round pulse takes priority over
  // everything, including a submit pulse in the same cycle and a compare
  // pending in CHECK. In CHECK, equality is tested before the attempt limit,
  // so a correct guess on the last allowed try counts as a win.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    guess_d    = guess_q;
    attempts_d = attempts_q;
    hint_d     = hint_q;
    done_d     = done_q;
    if (nr_p) begin
      target_d   = lfsr_q;
      attempts_d = 3'd0;
      hint_d     = HINT_NONE;
      done_d     = 1'b0;
      state_d    = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (sub_p) begin
            guess_d = guess;
            state_d = CHECK;
          end
        end
        CHECK: begin
          hint_d     = hint_of(guess_q, target_q);
          attempts_d = attempts_inc;
          if (guess_q == target_q) begin
            done_d  = 1'b1;
            state_d = WIN;
          end else if (attempts_inc == MAX_ATTEMPTS) begin
            done_d  = 1'b1;
            state_d = LOSE;
          end else begin
            state_d = ARMED;
          end
        end
        IDLE, WIN, LOSE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and round registers. The reset is asynchronous, so pulling rst low
  // in the middle of a round wipes that round at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      target_q   <= 6'h00;
      guess_q    <= 6'h00;
      attempts_q <= 3'd0;
      hint_q     <= HINT_NONE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      guess_q    <= guess_d;
      attempts_q <= attempts_d;
      hint_q     <= hint_d;
      done_q     <= done_d;
    end
  end

  assign result     = {done_q, attempts_q, hint_q};
  assign target_dbg = target_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_guess_round_ctrl
// Directed, table-driven bench for guess_round_ctrl. Inputs are driven and
// outputs sampled on the falling clock edge. A reference LFSR lets each round
// start at the cycle that makes the target a chosen value (37), so that every
// expected result in the table can be written by hand.
// -----------------------------------------------------------------------------
module tb_guess_round_ctrl;
  import guess_game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] guess = 6'd0;
  logic       submit = 1'b0;
  logic       new_round = 1'b0;
  logic [5:0] result;
  logic [5:0] target_dbg;

  int         passCount = 0;
  int         checkCount = 0;
  logic [5:0] mdlLfsr;
  logic [5:0] lastExp = 6'd0;
  logic [5:0] expTarget;

  typedef struct {
    bit         nr;
    logic [5:0] guess;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[21];

  guess_round_ctrl #(.MAX_TRIES(7), .SEED(6'h01)) dut (
    .clk        (clk),
    .rst        (rst),
    .guess      (guess),
    .submit     (submit),
    .new_round  (new_round),
    .result     (result),
    .target_dbg (target_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lfsrStep(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4]};
  endfunction

  function automatic logic [5:0] step3(input logic [5:0] v);
    return lfsrStep(lfsrStep(lfsrStep(v)));
  endfunction

  // Reference LFSR, started from the same seed under the same reset
  always @(posedge clk or negedge rst) begin
    if (!rst) mdlLfsr <= 6'h01;
    else      mdlLfsr <= lfsrStep(mdlLfsr);
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Hold the guess for 3 cycles, then give submit a one-cycle rise. Check
  // that result has not yet changed 4 falling edges later, and that it holds
  // the expected value on the 5th.
  task automatic applyStimulus(input logic [5:0] g, input logic [5:0] exp, input string name);
    guess = g;
    repeat (3) @(negedge clk);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput({name, " latency"}, {2'b00, result}, {2'b00, lastExp});
    @(negedge clk);
    checkOutput(name, {2'b00, result}, {2'b00, exp});
    lastExp = exp;
    repeat (2) @(negedge clk);
  endtask

  // Raise new_round on the falling edge whose LFSR value, 3 steps on, is tgt
  task automatic startRound(input logic [5:0] tgt);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (step3(mdlLfsr) == tgt) found = 1'b1;
    end
    if (!found) begin
      checkCount++;
      $display("[TB] FAIL round start timeout: got no slot, expected target %0d", tgt);
    end
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("round target", {2'b00, target_dbg}, {2'b00, tgt});
    checkOutput("round cleared", {2'b00, result}, 8'h00);
    lastExp = 6'd0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // win on the first try, then a submit after the win is ignored
    vecs[0]  = '{1'b1, 6'd37, 6'b1_001_11};
    vecs[1]  = '{1'b0, 6'd20, 6'b1_001_11};
    // hint direction
    vecs[2]  = '{1'b1, 6'd10, 6'b0_001_01};
    vecs[3]  = '{1'b0, 6'd50, 6'b0_010_10};
    vecs[4]  = '{1'b0, 6'd37, 6'b1_011_11};
    // seven wrong guesses lose; the eighth submit is ignored
    vecs[5]  = '{1'b1, 6'd0,  6'b0_001_01};
    vecs[6]  = '{1'b0, 6'd63, 6'b0_010_10};
    vecs[7]  = '{1'b0, 6'd36, 6'b0_011_01};
    vecs[8]  = '{1'b0, 6'd38, 6'b0_100_10};
    vecs[9]  = '{1'b0, 6'd1,  6'b0_101_01};
    vecs[10] = '{1'b0, 6'd62, 6'b0_110_10};
    vecs[11] = '{1'b0, 6'd20, 6'b1_111_01};
    vecs[12] = '{1'b0, 6'd37, 6'b1_111_01};
    // a correct guess on the seventh try wins
    vecs[13] = '{1'b1, 6'd0,  6'b0_001_01};
    vecs[14] = '{1'b0, 6'd63, 6'b0_010_10};
    vecs[15] = '{1'b0, 6'd36, 6'b0_011_01};
    vecs[16] = '{1'b0, 6'd38, 6'b0_100_10};
    vecs[17] = '{1'b0, 6'd1,  6'b0_101_01};
    vecs[18] = '{1'b0, 6'd62, 6'b0_110_10};
    vecs[19] = '{1'b0, 6'd37, 6'b1_111_11};
    // a fresh round
    vecs[20] = '{1'b1, 6'd50, 6'b0_001_10};

    // reset, then sit idle; a submit while in IDLE is ignored
    repeat (3) @(negedge clk);
    checkOutput("reset result", {2'b00, result}, 8'h00);
    checkOutput("reset target", {2'b00, target_dbg}, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle result", {2'b00, result}, 8'h00);
    applyStimulus(6'd5, 6'd0, "idle submit");
    checkOutput("idle state", 8'(dut.state_q), 8'(IDLE));

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].nr) startRound(6'd37);
      applyStimulus(vecs[i].guess, vecs[i].exp, $sformatf("row%0d", i));
    end

    // new_round and submit rise together: new_round wins, submit is dropped
    startRound(6'd37);
    applyStimulus(6'd10, 6'b0_001_01, "pre-simul");
    guess = 6'd37;
    repeat (3) @(negedge clk);
    expTarget = step3(mdlLfsr);
    submit = 1'b1;
    new_round = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    new_round = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("simul result", {2'b00, result}, 8'h00);
    checkOutput("simul target", {2'b00, target_dbg}, {2'b00, expTarget});
    checkOutput("simul state", 8'(dut.state_q), 8'(ARMED));
    repeat (2) @(negedge clk);

    // new_round lands in the CHECK cycle: the pending compare is discarded
    guess = 6'd10;
    repeat (3) @(negedge clk);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    expTarget = step3(mdlLfsr);
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("nr in check result", {2'b00, result}, 8'h00);
    checkOutput("nr in check target", {2'b00, target_dbg}, {2'b00, expTarget});
    @(negedge clk);
    checkOutput("nr in check state", 8'(dut.state_q), 8'(ARMED));
    checkOutput("nr in check hold", {2'b00, result}, 8'h00);
    repeat (2) @(negedge clk);

    // asynchronous reset dropped in the CHECK cycle
    startRound(6'd37);
    applyStimulus(6'd10, 6'b0_001_01, "pre-reset");
    guess = 6'd50;
    repeat (3) @(negedge clk);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("in check state", 8'(dut.state_q), 8'(CHECK));
    rst = 1'b0;
    #1;
    checkOutput("async rst result", {2'b00, result}, 8'h00);
    checkOutput("async rst state", 8'(dut.state_q), 8'(IDLE));
    checkOutput("async rst lfsr", {2'b00, dut.lfsr_q}, 8'h01);
    checkOutput("async rst target", {2'b00, target_dbg}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("post rst result", {2'b00, result}, 8'h00);
    checkOutput("post rst state", 8'(dut.state_q), 8'(IDLE));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
